issue_ctrl: RTL and testbench

Dual-issue issue stage sitting directly upstream of the register-read (RR) stage. Accepts a decoded instruction pair from decode and detects intra-pair hazards and load-use hazards against the pair currently in RR. Registers the preRR bundle that RR consumes: the pair, a split single instruction, or a NOP bubble. Drives a stall back to decode and flushes on branch-mispredict `fail`.

---
 rtl/issue_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_issue_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue stage feeding register-read (RR).
// Detects intra-pair hazards (split into two single issues through a one-entry
// hold buffer) and load-use hazards against RR (bubble + stall), flushes on fail.
// Optional build macro: SERIAL_ISSUE_EN forces every valid pair to be split.

`ifndef ALU_NOP
`define ALU_NOP 6'd0
`endif
`ifndef OP_TYPE_NONE
`define OP_TYPE_NONE 2'd0
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif

module issue_ctrl #(
    parameter logic [5:0] NOP_ALUCODE = `ALU_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fail,
    input  logic        dec_valid1,
    input  logic        dec_valid2,
    input  logic [31:0] dec_pc1,
    input  logic [31:0] dec_pc2,
    input  logic [31:0] dec_prepc1,
    input  logic [31:0] dec_prepc2,
    input  logic [6:0]  dec_opcode1,
    input  logic [6:0]  dec_opcode2,
    input  logic [2:0]  dec_funct3_1,
    input  logic [2:0]  dec_funct3_2,
    input  logic [5:0]  dec_alucode1,
    input  logic [5:0]  dec_alucode2,
    input  logic [1:0]  dec_op1type1,
    input  logic [1:0]  dec_op2type1,
    input  logic [1:0]  dec_op1type2,
    input  logic [1:0]  dec_op2type2,
    input  logic [31:0] dec_imm1,
    input  logic [31:0] dec_imm2,
    input  logic [4:0]  dec_dst1,
    input  logic [4:0]  dec_dst2,
    input  logic [4:0]  dec_src11,
    input  logic [4:0]  dec_src12,
    input  logic [4:0]  dec_src21,
    input  logic [4:0]  dec_src22,
    input  logic        dec_we1,
    input  logic        dec_we2,
    input  logic        dec_ld1,
    input  logic        dec_ld2,
    input  logic        dec_st1,
    input  logic        dec_st2,
    input  logic        is_loadRR1,
    input  logic        is_loadRR2,
    input  logic [4:0]  dstregRR1,
    input  logic [4:0]  dstregRR2,
    output logic        stall,
    output logic [4:0]  dstregpreRR1,
    output logic [4:0]  dstregpreRR2,
    output logic [31:0] preRRpc1,
    output logic [31:0] preRRpc2,
    output logic [5:0]  alucodepreRR1,
    output logic [5:0]  alucodepreRR2,
    output logic [1:0]  aluop1_typepreRR1,
    output logic [1:0]  aluop1_typepreRR2,
    output logic [1:0]  aluop2_typepreRR1,
    output logic [1:0]  aluop2_typepreRR2,
    output logic [31:0] immpreRR1,
    output logic [31:0] immpreRR2,
    output logic        reg_wepreRR1,
    output logic        reg_wepreRR2,
    output logic        is_loadpreRR1,
    output logic        is_loadpreRR2,
    output logic        is_storepreRR1,
    output logic        is_storepreRR2,
    output logic [2:0]  funct3preRR1,
    output logic [2:0]  funct3preRR2,
    output logic [4:0]  srcreg11,
    output logic [4:0]  srcreg12,
    output logic [4:0]  srcreg21,
    output logic [4:0]  srcreg22,
    output logic [31:0] prePC1,
    output logic [31:0] prePC2,
    output logic [6:0]  opcodepreRR1,
    output logic [6:0]  opcodepreRR2
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] prepc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [5:0]  alucode;
        logic [1:0]  op1type;
        logic [1:0]  op2type;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic        we;
        logic        ld;
        logic        st;
    } slot_t;

    typedef enum logic [0:0] {StIssue, StHeld} state_e;

    function automatic slot_t nop_slot();
        slot_t s;
        s         = '0;
        s.alucode = NOP_ALUCODE;
        s.op1type = `OP_TYPE_NONE;
        s.op2type = `OP_TYPE_NONE;
        return s;
    endfunction

    function automatic slot_t reset_slot();
        slot_t s;
        s         = '0;
        s.alucode = `ALU_NOP;
        s.op1type = `OP_TYPE_NONE;
        s.op2type = `OP_TYPE_NONE;
        s.we      = `DISABLE;
        s.ld      = `DISABLE;
        s.st      = `DISABLE;
        return s;
    endfunction

    // True when either source reads a register still being loaded in RR (x0 never counts).
    function automatic logic load_use(input logic [4:0] sa, input logic [4:0] sb,
                                      input logic l1, input logic [4:0] d1,
                                      input logic l2, input logic [4:0] d2);
        return (l1 && (d1 != 5'd0) && ((sa == d1) || (sb == d1))) ||
               (l2 && (d2 != 5'd0) && ((sa == d2) || (sb == d2)));
    endfunction

    state_e state_q, state_d;
    slot_t  hold_q, hold_d;
    logic   hold_valid_q, hold_valid_d;
    slot_t  out1_q, out1_d, out2_q, out2_d;
    slot_t  slot1, slot2;
    logic   lu_dec, lu_hold, split;

    assign slot1 = '{pc: dec_pc1, prepc: dec_prepc1, opcode: dec_opcode1,
                     funct3: dec_funct3_1, alucode: dec_alucode1, op1type: dec_op1type1,
                     op2type: dec_op2type1, imm: dec_imm1, dst: dec_dst1, src1: dec_src11,
                     src2: dec_src12, we: dec_we1, ld: dec_ld1, st: dec_st1};
    assign slot2 = '{pc: dec_pc2, prepc: dec_prepc2, opcode: dec_opcode2,
                     funct3: dec_funct3_2, alucode: dec_alucode2, op1type: dec_op1type2,
                     op2type: dec_op2type2, imm: dec_imm2, dst: dec_dst2, src1: dec_src21,
                     src2: dec_src22, we: dec_we2, ld: dec_ld2, st: dec_st2};

    assign lu_dec =
        (dec_valid1 && load_use(dec_src11, dec_src12, is_loadRR1, dstregRR1,
                                is_loadRR2, dstregRR2)) ||
        (dec_valid2 && load_use(dec_src21, dec_src22, is_loadRR1, dstregRR1,
                                is_loadRR2, dstregRR2));
    assign lu_hold = load_use(hold_q.src1, hold_q.src2, is_loadRR1, dstregRR1,
                              is_loadRR2, dstregRR2);

`ifdef SERIAL_ISSUE_EN
    assign split = dec_valid1 && dec_valid2;
`else
    // RAW inside the pair, or two memory ops (single memory port); WAW is left to RR.
    logic raw_pair, mem_pair;
    assign raw_pair = dec_we1 && (dec_dst1 != 5'd0) &&
                      ((dec_src21 == dec_dst1) || (dec_src22 == dec_dst1));
    assign mem_pair = (dec_ld1 | dec_st1) && (dec_ld2 | dec_st2);
    assign split    = dec_valid1 && dec_valid2 && (raw_pair || mem_pair);
`endif

    // Next-state, hold buffer and bundle selection; fail overrides everything.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        out1_d       = nop_slot();
        out2_d       = nop_slot();
        stall        = 1'b0;
        if (fail) begin
            state_d      = StIssue;
            hold_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIssue: begin
                    if (lu_dec) begin
                        stall = 1'b1;
                    end else if (split) begin
                        out1_d       = slot1;
                        hold_d       = slot2;
                        hold_valid_d = 1'b1;
                        state_d      = StHeld;
                    end else begin
                        if (dec_valid1) out1_d = slot1;
                        if (dec_valid2) out2_d = slot2;
                    end
                end
                StHeld: begin
                    stall = 1'b1;
                    if (!lu_hold) begin
                        out1_d       = hold_q;
                        hold_valid_d = 1'b0;
                        state_d      = StIssue;
                    end
                end
                default: state_d = StIssue;
            endcase
        end
    end

    // State, hold buffer and registered preRR bundle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIssue;
            hold_q       <= reset_slot();
            hold_valid_q <= 1'b0;
            out1_q       <= reset_slot();
            out2_q       <= reset_slot();
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            out1_q       <= out1_d;
            out2_q       <= out2_d;
        end
    end

    assign dstregpreRR1      = out1_q.dst;
    assign dstregpreRR2      = out2_q.dst;
    assign preRRpc1          = out1_q.pc;
    assign preRRpc2          = out2_q.pc;
    assign alucodepreRR1     = out1_q.alucode;
    assign alucodepreRR2     = out2_q.alucode;
    assign aluop1_typepreRR1 = out1_q.op1type;
    assign aluop1_typepreRR2 = out2_q.op1type;
    assign aluop2_typepreRR1 = out1_q.op2type;
    assign aluop2_typepreRR2 = out2_q.op2type;
    assign immpreRR1         = out1_q.imm;
    assign immpreRR2         = out2_q.imm;
    assign reg_wepreRR1      = out1_q.we;
    assign reg_wepreRR2      = out2_q.we;
    assign is_loadpreRR1     = out1_q.ld;
    assign is_loadpreRR2     = out2_q.ld;
    assign is_storepreRR1    = out1_q.st;
    assign is_storepreRR2    = out2_q.st;
    assign funct3preRR1      = out1_q.funct3;
    assign funct3preRR2      = out2_q.funct3;
    assign srcreg11          = out1_q.src1;
    assign srcreg12          = out1_q.src2;
    assign srcreg21          = out2_q.src1;
    assign srcreg22          = out2_q.src2;
    assign prePC1            = out1_q.prepc;
    assign prePC2            = out2_q.prepc;
    assign opcodepreRR1      = out1_q.opcode;
    assign opcodepreRR2      = out2_q.opcode;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl.
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fail;
    logic        dec_valid1, dec_valid2;
    logic [31:0] dec_pc1, dec_pc2, dec_prepc1, dec_prepc2;
    logic [6:0]  dec_opcode1, dec_opcode2;
    logic [2:0]  dec_funct3_1, dec_funct3_2;
    logic [5:0]  dec_alucode1, dec_alucode2;
    logic [1:0]  dec_op1type1, dec_op2type1, dec_op1type2, dec_op2type2;
    logic [31:0] dec_imm1, dec_imm2;
    logic [4:0]  dec_dst1, dec_dst2, dec_src11, dec_src12, dec_src21, dec_src22;
    logic        dec_we1, dec_we2, dec_ld1, dec_ld2, dec_st1, dec_st2;
    logic        is_loadRR1, is_loadRR2;
    logic [4:0]  dstregRR1, dstregRR2;
    logic        stall;
    logic [4:0]  dstregpreRR1, dstregpreRR2;
    logic [31:0] preRRpc1, preRRpc2;
    logic [5:0]  alucodepreRR1, alucodepreRR2;
    logic [1:0]  aluop1_typepreRR1, aluop1_typepreRR2, aluop2_typepreRR1, aluop2_typepreRR2;
    logic [31:0] immpreRR1, immpreRR2;
    logic        reg_wepreRR1, reg_wepreRR2, is_loadpreRR1, is_loadpreRR2;
    logic        is_storepreRR1, is_storepreRR2;
    logic [2:0]  funct3preRR1, funct3preRR2;
    logic [4:0]  srcreg11, srcreg12, srcreg21, srcreg22;
    logic [31:0] prePC1, prePC2;
    logic [6:0]  opcodepreRR1, opcodepreRR2;

    localparam logic [5:0] NOP_ALU = 6'd0;
    localparam logic [5:0] ADD_ALU = 6'd3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_ctrl dut (
        .clk(clk), .rst(rst), .fail(fail),
        .dec_valid1(dec_valid1), .dec_valid2(dec_valid2),
        .dec_pc1(dec_pc1), .dec_pc2(dec_pc2), .dec_prepc1(dec_prepc1), .dec_prepc2(dec_prepc2),
        .dec_opcode1(dec_opcode1), .dec_opcode2(dec_opcode2),
        .dec_funct3_1(dec_funct3_1), .dec_funct3_2(dec_funct3_2),
        .dec_alucode1(dec_alucode1), .dec_alucode2(dec_alucode2),
        .dec_op1type1(dec_op1type1), .dec_op2type1(dec_op2type1),
        .dec_op1type2(dec_op1type2), .dec_op2type2(dec_op2type2),
        .dec_imm1(dec_imm1), .dec_imm2(dec_imm2), .dec_dst1(dec_dst1), .dec_dst2(dec_dst2),
        .dec_src11(dec_src11), .dec_src12(dec_src12), .dec_src21(dec_src21),
        .dec_src22(dec_src22), .dec_we1(dec_we1), .dec_we2(dec_we2), .dec_ld1(dec_ld1),
        .dec_ld2(dec_ld2), .dec_st1(dec_st1), .dec_st2(dec_st2),
        .is_loadRR1(is_loadRR1), .is_loadRR2(is_loadRR2),
        .dstregRR1(dstregRR1), .dstregRR2(dstregRR2), .stall(stall),
        .dstregpreRR1(dstregpreRR1), .dstregpreRR2(dstregpreRR2),
        .preRRpc1(preRRpc1), .preRRpc2(preRRpc2),
        .alucodepreRR1(alucodepreRR1), .alucodepreRR2(alucodepreRR2),
        .aluop1_typepreRR1(aluop1_typepreRR1), .aluop1_typepreRR2(aluop1_typepreRR2),
        .aluop2_typepreRR1(aluop2_typepreRR1), .aluop2_typepreRR2(aluop2_typepreRR2),
        .immpreRR1(immpreRR1), .immpreRR2(immpreRR2),
        .reg_wepreRR1(reg_wepreRR1), .reg_wepreRR2(reg_wepreRR2),
        .is_loadpreRR1(is_loadpreRR1), .is_loadpreRR2(is_loadpreRR2),
        .is_storepreRR1(is_storepreRR1), .is_storepreRR2(is_storepreRR2),
        .funct3preRR1(funct3preRR1), .funct3preRR2(funct3preRR2),
        .srcreg11(srcreg11), .srcreg12(srcreg12), .srcreg21(srcreg21), .srcreg22(srcreg22),
        .prePC1(prePC1), .prePC2(prePC2),
        .opcodepreRR1(opcodepreRR1), .opcodepreRR2(opcodepreRR2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int n, input logic v, input logic [31:0] pc,
                            input logic [4:0] dst, input logic [4:0] s1, input logic [4:0] s2,
                            input logic we, input logic ld, input logic st);
        logic [6:0] opc;
        opc = ld ? 7'h03 : (st ? 7'h23 : 7'h13);
        if (n == 1) begin
            dec_valid1 = v; dec_pc1 = pc; dec_prepc1 = pc + 32'd4; dec_opcode1 = opc;
            dec_funct3_1 = (ld || st) ? 3'd2 : 3'd0; dec_alucode1 = ADD_ALU;
            dec_op1type1 = 2'd1; dec_op2type1 = 2'd2; dec_imm1 = pc;
            dec_dst1 = dst; dec_src11 = s1; dec_src12 = s2;
            dec_we1 = we; dec_ld1 = ld; dec_st1 = st;
        end else begin
            dec_valid2 = v; dec_pc2 = pc; dec_prepc2 = pc + 32'd4; dec_opcode2 = opc;
            dec_funct3_2 = (ld || st) ? 3'd2 : 3'd0; dec_alucode2 = ADD_ALU;
            dec_op1type2 = 2'd1; dec_op2type2 = 2'd2; dec_imm2 = pc;
            dec_dst2 = dst; dec_src21 = s1; dec_src22 = s2;
            dec_we2 = we; dec_ld2 = ld; dec_st2 = st;
        end
    endtask

    task automatic clear_dec();
        set_slot(1, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        set_slot(2, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        is_loadRR1 = 1'b0; is_loadRR2 = 1'b0; dstregRR1 = 5'd0; dstregRR2 = 5'd0;
        fail = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_dec();
        #2;
        checks++; if (preRRpc1 !== 32'h0) begin errors++; $display("FAIL reset_pc1: got %h want %h", preRRpc1, 32'h0); end
        checks++; if (alucodepreRR1 !== NOP_ALU) begin errors++; $display("FAIL reset_alu1: got %h want %h", alucodepreRR1, NOP_ALU); end
        checks++; if (aluop1_typepreRR2 !== 2'd0) begin errors++; $display("FAIL reset_optype2: got %h want %h", aluop1_typepreRR2, 2'd0); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want %b", stall, 1'b0); end
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_independent();
        set_slot(1, 1'b1, 32'h100, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        set_slot(2, 1'b1, 32'h104, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL indep_stall: got %b want %b", stall, 1'b0); end
        tick();
        checks++; if (preRRpc1 !== 32'h100) begin errors++; $display("FAIL indep_pc1: got %h want %h", preRRpc1, 32'h100); end
        checks++; if (prePC1 !== 32'h104) begin errors++; $display("FAIL indep_prepc1: got %h want %h", prePC1, 32'h104); end
        checks++; if (alucodepreRR1 !== ADD_ALU) begin errors++; $display("FAIL indep_alu1: got %h want %h", alucodepreRR1, ADD_ALU); end
`ifdef SERIAL_ISSUE_EN
        checks++; if (preRRpc2 !== 32'h0) begin errors++; $display("FAIL serial_pc2: got %h want %h", preRRpc2, 32'h0); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL serial_stall: got %b want %b", stall, 1'b1); end
        tick();
        checks++; if (preRRpc1 !== 32'h104) begin errors++; $display("FAIL serial_drain: got %h want %h", preRRpc1, 32'h104); end
`else
        checks++; if (preRRpc2 !== 32'h104) begin errors++; $display("FAIL indep_pc2: got %h want %h", preRRpc2, 32'h104); end
        checks++; if (dstregpreRR2 !== 5'd2) begin errors++; $display("FAIL indep_dst2: got %h want %h", dstregpreRR2, 5'd2); end
`endif
        clear_dec();
        tick();
        checks++; if (preRRpc1 !== 32'h0) begin errors++; $display("FAIL idle_pc1: got %h want %h", preRRpc1, 32'h0); end
    endtask

    task automatic test_raw_split();
        set_slot(1, 1'b1, 32'h100, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        set_slot(2, 1'b1, 32'h104, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_stall0: got %b want %b", stall, 1'b0); end
        tick();
        checks++; if (preRRpc1 !== 32'h100) begin errors++; $display("FAIL raw_pc1: got %h want %h", preRRpc1, 32'h100); end
        checks++; if (preRRpc2 !== 32'h0) begin errors++; $display("FAIL raw_pc2_nop: got %h want %h", preRRpc2, 32'h0); end
        checks++; if (alucodepreRR2 !== NOP_ALU) begin errors++; $display("FAIL raw_alu2_nop: got %h want %h", alucodepreRR2, NOP_ALU); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_held: got %b want %b", stall, 1'b1); end
        tick();
        checks++; if (preRRpc1 !== 32'h104) begin errors++; $display("FAIL raw_held_pc1: got %h want %h", preRRpc1, 32'h104); end
        checks++; if (srcreg11 !== 5'd5) begin errors++; $display("FAIL raw_held_src: got %h want %h", srcreg11, 5'd5); end
        checks++; if (dstregpreRR1 !== 5'd6) begin errors++; $display("FAIL raw_held_dst: got %h want %h", dstregpreRR1, 5'd6); end
        clear_dec();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_stall_after: got %b want %b", stall, 1'b0); end
    endtask

    task automatic test_mem_pair();
        set_slot(1, 1'b1, 32'h200, 5'd7, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
        set_slot(2, 1'b1, 32'h204, 5'd0, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (is_loadpreRR1 !== 1'b1) begin errors++; $display("FAIL mem_ld1: got %b want %b", is_loadpreRR1, 1'b1); end
        checks++; if (preRRpc2 !== 32'h0) begin errors++; $display("FAIL mem_pc2_nop: got %h want %h", preRRpc2, 32'h0); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mem_stall: got %b want %b", stall, 1'b1); end
        tick();
        checks++; if (preRRpc1 !== 32'h204) begin errors++; $display("FAIL mem_held_pc1: got %h want %h", preRRpc1, 32'h204); end
        checks++; if (is_storepreRR1 !== 1'b1) begin errors++; $display("FAIL mem_st1: got %b want %b", is_storepreRR1, 1'b1); end
        clear_dec();
    endtask

    task automatic test_waw_and_x0();
        // Same destination in both slots, plus slot 2 reading x0 written by slot 1.
        set_slot(1, 1'b1, 32'h300, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        set_slot(2, 1'b1, 32'h304, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        is_loadRR1 = 1'b1; dstregRR1 = 5'd0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want %b", stall, 1'b0); end
        tick();
`ifndef SERIAL_ISSUE_EN
        checks++; if (preRRpc2 !== 32'h304) begin errors++; $display("FAIL x0_pc2: got %h want %h", preRRpc2, 32'h304); end
`endif
        clear_dec();
        #1;
        set_slot(1, 1'b1, 32'h310, 5'd9, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        set_slot(2, 1'b1, 32'h314, 5'd9, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (preRRpc1 !== 32'h310) begin errors++; $display("FAIL waw_pc1: got %h want %h", preRRpc1, 32'h310); end
`ifdef SERIAL_ISSUE_EN
        tick();
        checks++; if (preRRpc1 !== 32'h314) begin errors++; $display("FAIL waw_serial_pc1: got %h want %h", preRRpc1, 32'h314); end
`else
        checks++; if (preRRpc2 !== 32'h314) begin errors++; $display("FAIL waw_pc2: got %h want %h", preRRpc2, 32'h314); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_stall: got %b want %b", stall, 1'b0); end
`endif
        clear_dec();
    endtask

    task automatic test_load_use();
        set_slot(1, 1'b1, 32'h400, 5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
        set_slot(2, 1'b1, 32'h404, 5'd10, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        is_loadRR1 = 1'b1; dstregRR1 = 5'd3;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want %b", stall, 1'b1); end
        tick();
        checks++; if (preRRpc1 !== 32'h0) begin errors++; $display("FAIL lu_nop_pc1: got %h want %h", preRRpc1, 32'h0); end
        checks++; if (alucodepreRR1 !== NOP_ALU) begin errors++; $display("FAIL lu_nop_alu1: got %h want %h", alucodepreRR1, NOP_ALU); end
        is_loadRR1 = 1'b0; dstregRR1 = 5'd0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_clear_stall: got %b want %b", stall, 1'b0); end
        tick();
        checks++; if (preRRpc1 !== 32'h400) begin errors++; $display("FAIL lu_issue_pc1: got %h want %h", preRRpc1, 32'h400); end
        // RR slot 2 load against decode slot 2, second source.
        set_slot(1, 1'b1, 32'h410, 5'd11, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        set_slot(2, 1'b1, 32'h414, 5'd12, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0);
        is_loadRR2 = 1'b1; dstregRR2 = 5'd8;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_rr2_stall: got %b want %b", stall, 1'b1); end
        tick();
        checks++; if (preRRpc1 !== 32'h0) begin errors++; $display("FAIL lu_rr2_nop: got %h want %h", preRRpc1, 32'h0); end
        clear_dec();
    endtask

    task automatic test_held_load_use();
        set_slot(1, 1'b1, 32'h500, 5'd5, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
        set_slot(2, 1'b1, 32'h504, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        is_loadRR1 = 1'b1; dstregRR1 = 5'd5;
        tick();
        checks++; if (preRRpc1 !== 32'h0) begin errors++; $display("FAIL held_lu_nop: got %h want %h", preRRpc1, 32'h0); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL held_lu_stall: got %b want %b", stall, 1'b1); end
        is_loadRR1 = 1'b0; dstregRR1 = 5'd0;
        tick();
        checks++; if (preRRpc1 !== 32'h504) begin errors++; $display("FAIL held_lu_issue: got %h want %h", preRRpc1, 32'h504); end
        clear_dec();
    endtask

    task automatic test_fail_held();
        set_slot(1, 1'b1, 32'h600, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        set_slot(2, 1'b1, 32'h604, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        fail = 1'b1;
        tick();
        clear_dec();
        checks++; if (preRRpc1 !== 32'h0) begin errors++; $display("FAIL fail_nop_pc1: got %h want %h", preRRpc1, 32'h0); end
        checks++; if (preRRpc2 !== 32'h0) begin errors++; $display("FAIL fail_nop_pc2: got %h want %h", preRRpc2, 32'h0); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fail_stall: got %b want %b", stall, 1'b0); end
        tick();
        checks++; if (preRRpc1 !== 32'h0) begin errors++; $display("FAIL fail_no_replay: got %h want %h", preRRpc1, 32'h0); end
    endtask

    task automatic test_reset_mid_held();
        set_slot(1, 1'b1, 32'h700, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        set_slot(2, 1'b1, 32'h704, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        #2 rst = 1'b0;
        #1;
        checks++; if (preRRpc1 !== 32'h0) begin errors++; $display("FAIL rst_mid_pc1: got %h want %h", preRRpc1, 32'h0); end
        checks++; if (alucodepreRR1 !== NOP_ALU) begin errors++; $display("FAIL rst_mid_alu1: got %h want %h", alucodepreRR1, NOP_ALU); end
        checks++; if (reg_wepreRR1 !== 1'b0) begin errors++; $display("FAIL rst_mid_we1: got %b want %b", reg_wepreRR1, 1'b0); end
        rst = 1'b1;
        clear_dec();
        set_slot(1, 1'b1, 32'h800, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        set_slot(2, 1'b1, 32'h804, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want %b", stall, 1'b0); end
        tick();
        checks++; if (preRRpc1 !== 32'h800) begin errors++; $display("FAIL rst_after_pc1: got %h want %h", preRRpc1, 32'h800); end
        clear_dec();
        tick();
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_split();
        test_mem_pair();
        test_waw_and_x0();
        test_load_use();
        test_held_load_use();
        test_fail_held();
        test_reset_mid_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
